// File: rtl/accel_resp_pkg.sv
// accel_resp_pkg
// Shared definitions for the accelerometer SPI responder: register map
// addresses, the transfer FSM state type, and the DATA_READY bit position
// inside INT_SOURCE.
package accel_resp_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
    localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
    localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam int NUM_DATA_BYTES = 6;
    localparam int DATA_READY_BIT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RD   = 2'd2,
        WR   = 2'd3
    } spi_state_e;

    // True for the six axis data bytes (DATAX0..DATAZ1).
    function automatic logic is_data_addr(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
// Brings one asynchronous SPI pin into the clk domain through a STAGES-deep
// flop chain and flags its rising and falling edges.
// Ports:
//   clk      system clock
//   srst     synchronous active-high reset
//   pin_i    raw pin
//   level_o  synchronized level
//   rise_o   one-cycle pulse on a 0->1 transition of level_o
//   fall_o   one-cycle pulse on a 1->0 transition of level_o
// RESET_VAL sets the flop contents at reset so an idle-high pin does not
// produce a spurious edge when reset is released.
module spi_edge_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic srst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Bits [STAGES-1:0] are the synchronizer, bit STAGES holds the previous
    // synchronized level for edge detection.
    logic [STAGES:0] sync_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_q <= {(STAGES + 1){RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-1:0], pin_i};
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall_o  = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder
// Pin-level emulation of the board G-sensor on a 3-wire SPI bus
// (CPOL=1, CPHA=1, MSB first). Axis data comes from a sample-injection port.
// Ports:
//   clk_clk, reset_reset            clock and synchronous active-high reset
//   I2C_SCLK, G_SENSOR_CS_N         SPI clock (idles high) and chip select
//   sdat_in / sdat_out / sdat_oe    data pad; the tristate lives above
//   G_SENSOR_INT                    active-high interrupt
//   sample_valid, sample_x/y/z      one-cycle strobe loading 16-bit axis data
// Build option: define ACCEL_RESP_INT_EN to build DATA_READY and the
// interrupt output; otherwise INT_SOURCE reads 0 and G_SENSOR_INT is 0.
module accel_spi_responder
    import accel_resp_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        I2C_SCLK,
    input  logic        G_SENSOR_CS_N,
    input  logic        sdat_in,
    output logic        sdat_out,
    output logic        sdat_oe,
    output logic        G_SENSOR_INT,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z
);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic sdat_lvl, sdat_rise, sdat_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk(clk_clk), .srst(reset_reset), .pin_i(I2C_SCLK),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk_clk), .srst(reset_reset), .pin_i(G_SENSOR_CS_N),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_edge_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdat (
        .clk(clk_clk), .srst(reset_reset), .pin_i(sdat_in),
        .level_o(sdat_lvl), .rise_o(sdat_rise), .fall_o(sdat_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, cs_lvl, sdat_rise, sdat_fall};

    // Transfer state
    spi_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       mb_q, mb_d;
    logic [5:0] addr_q, addr_d;
    logic       oe_q, oe_d;
    logic       sdo_q, sdo_d;
    logic       shadow_valid_q, shadow_valid_d;

    // Register storage
    logic [7:0] power_ctl_q, int_enable_q, int_map_q, data_format_q;
    logic [7:0] data_q   [NUM_DATA_BYTES];
    logic [7:0] shadow_q [NUM_DATA_BYTES];
    logic [7:0] int_source;

    logic [7:0] shift_in;
    logic [5:0] step_addr;
    logic       cmd_last, rd_last, wr_last;
    logic       load_en, wr_en;
    logic [5:0] load_addr;
    logic [7:0] load_byte;
    logic [2:0] data_idx;

    assign shift_in  = {shift_q[6:0], sdat_lvl};
    assign step_addr = mb_q ? addr_q + 6'd1 : addr_q;

    assign cmd_last = (state_q == CMD) && sclk_rise && (bit_cnt_q == 3'd7);
    assign rd_last  = (state_q == RD)  && sclk_fall && (bit_cnt_q == 3'd7);
    assign wr_last  = (state_q == WR)  && sclk_rise && (bit_cnt_q == 3'd7);

    // A read byte is loaded at the end of a read command, and again after
    // every data byte for the following address (the master may keep
    // clocking). A CS_N rise in the same cycle wins and cancels everything.
    assign load_en   = ~cs_rise & ((cmd_last & shift_in[7]) | rd_last);
    assign load_addr = cmd_last ? shift_in[5:0] : step_addr;
    assign wr_en     = ~cs_rise & wr_last;

    // 0x32..0x37 have low bits 2..7, so subtracting 2 gives the byte index.
    assign data_idx = load_addr[2:0] - 3'd2;

    always_comb begin
        load_byte = 8'h00;
        case (load_addr)
            ADDR_DEVID:       load_byte = DEVID;
            ADDR_POWER_CTL:   load_byte = power_ctl_q;
            ADDR_INT_ENABLE:  load_byte = int_enable_q;
            ADDR_INT_MAP:     load_byte = int_map_q;
            ADDR_INT_SOURCE:  load_byte = int_source;
            ADDR_DATA_FORMAT: load_byte = data_format_q;
            default: begin
                if (is_data_addr(load_addr)) begin
                    load_byte = shadow_valid_q ? shadow_q[data_idx] : data_q[data_idx];
                end
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        mb_d           = mb_q;
        addr_d         = addr_q;
        oe_d           = oe_q;
        sdo_d          = sdo_q;
        shadow_valid_d = shadow_valid_q;

        if (cs_rise) begin
            state_d        = IDLE;
            bit_cnt_d      = 3'd0;
            oe_d           = 1'b0;
            shadow_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d        = CMD;
                        bit_cnt_d      = 3'd0;
                        shadow_valid_d = 1'b0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            mb_d   = shift_in[6];
                            addr_d = shift_in[5:0];
                            if (shift_in[7]) begin
                                state_d = RD;
                                shift_d = load_byte;
                            end else begin
                                state_d = WR;
                            end
                        end
                    end
                end
                RD: begin
                    if (sclk_fall) begin
                        sdo_d     = shift_q[7];
                        oe_d      = 1'b1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = step_addr;
                            shift_d = load_byte;
                        end
                    end
                end
                WR: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = step_addr;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            // Loading DATAX0 freezes all six bytes for the rest of the frame.
            if (load_en && (load_addr == ADDR_DATAX0)) begin
                shadow_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            mb_q           <= 1'b0;
            addr_q         <= 6'h00;
            oe_q           <= 1'b0;
            sdo_q          <= 1'b0;
            shadow_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            mb_q           <= mb_d;
            addr_q         <= addr_d;
            oe_q           <= oe_d;
            sdo_q          <= sdo_d;
            shadow_valid_q <= shadow_valid_d;
        end
    end

    logic [47:0] sample_bytes;
    assign sample_bytes = {sample_z, sample_y, sample_x};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            power_ctl_q   <= 8'h00;
            int_enable_q  <= 8'h00;
            int_map_q     <= 8'h00;
            data_format_q <= 8'h00;
            for (int i = 0; i < NUM_DATA_BYTES; i++) begin
                data_q[i]   <= 8'h00;
                shadow_q[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                case (addr_q)
                    ADDR_POWER_CTL:   power_ctl_q   <= shift_in;
                    ADDR_INT_ENABLE:  int_enable_q  <= shift_in;
                    ADDR_INT_MAP:     int_map_q     <= shift_in;
                    ADDR_DATA_FORMAT: data_format_q <= shift_in;
                    default: ;
                endcase
            end
            // The shadow copies the registered live bytes, so a sample landing
            // in the same cycle goes to the live set only.
            if (load_en && (load_addr == ADDR_DATAX0)) begin
                for (int i = 0; i < NUM_DATA_BYTES; i++) begin
                    shadow_q[i] <= data_q[i];
                end
            end
            if (sample_valid) begin
                for (int i = 0; i < NUM_DATA_BYTES; i++) begin
                    data_q[i] <= sample_bytes[8*i +: 8];
                end
            end
        end
    end

`ifdef ACCEL_RESP_INT_EN
    logic data_ready_q;
    logic int_q;

    always_comb begin
        int_source                 = 8'h00;
        int_source[DATA_READY_BIT] = data_ready_q;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            data_ready_q <= 1'b0;
            int_q        <= 1'b0;
        end else begin
            // Set has priority over the read-triggered clear.
            if (sample_valid) begin
                data_ready_q <= 1'b1;
            end else if (load_en && is_data_addr(load_addr)) begin
                data_ready_q <= 1'b0;
            end
            int_q <= |(int_source & int_enable_q & ~int_map_q);
        end
    end

    assign G_SENSOR_INT = int_q;
`else
    assign int_source   = 8'h00;
    assign G_SENSOR_INT = 1'b0;
`endif

    assign sdat_out = sdo_q;
    assign sdat_oe  = oe_q;

endmodule
